// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the CDC FIFO write-side arbiter.
package cdc_fifo_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // Round-robin successor of an index, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/cdc_fifo_write_arbiter_picker.sv
// Combinational round-robin picker: first unmasked request at or after the
// pointer, wrapping modulo NUM_REQUESTERS.
module round_robin_picker #(
  parameter int NUM_REQUESTERS = 4,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] req_i,
  input  logic [NUM_REQUESTERS-1:0] mask_i,
  input  logic [ID_WIDTH-1:0]       ptr_i,
  output logic                      found_o,
  output logic [ID_WIDTH-1:0]       idx_o
);

  logic [NUM_REQUESTERS-1:0] cand_s;
  logic [ID_WIDTH-1:0]       pos_s;
  logic                      found_s;
  logic [ID_WIDTH-1:0]       idx_s;

  assign cand_s = req_i & ~mask_i;

  // Scan candidates starting from the pointer; the first hit wins.
  always_comb begin
    found_s = 1'b0;
    idx_s   = '0;
    pos_s   = ptr_i;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      pos_s = ID_WIDTH'((int'(ptr_i) + i) % NUM_REQUESTERS);
      if (!found_s && cand_s[pos_s]) begin
        found_s = 1'b1;
        idx_s   = pos_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign found_o = found_s;
  assign idx_o   = idx_s;

endmodule

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter sharing the CDC FIFO write port between requesters.
// Define CDC_FIFO_ARB_BURST_LOCK_EN to hold the grant until req_last.
module cdc_fifo_write_arbiter
  import cdc_fifo_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [NUM_REQUESTERS-1:0]          req_valid,
  input  logic [NUM_REQUESTERS-1:0]          req_last,
  input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQUESTERS-1:0]          req_ready,
  input  logic                               full,
  output logic                               increment,
  output logic                               write_enable,
  output logic [DATA_WIDTH-1:0]              write_data,
  output logic                               grant_valid,
  output logic [ID_WIDTH-1:0]                grant_id
);

  arb_state_t                state_q;
  logic [ID_WIDTH-1:0]       grant_id_q;
  logic [ID_WIDTH-1:0]       prio_q;
  logic                      grant_valid_q;

  logic                      granted_s;
  logic                      transfer_s;
  logic                      release_s;
  logic [ID_WIDTH-1:0]       prio_next_s;
  logic [NUM_REQUESTERS-1:0] pick_mask_s;
  logic [ID_WIDTH-1:0]       pick_ptr_s;
  logic                      pick_found_s;
  logic [ID_WIDTH-1:0]       pick_idx_s;

  assign granted_s   = (state_q == ARB_GRANTED);
  assign transfer_s  = granted_s & req_valid[grant_id_q] & ~full;
  assign prio_next_s = ID_WIDTH'(rr_next(int'(grant_id_q), NUM_REQUESTERS));

`ifdef CDC_FIFO_ARB_BURST_LOCK_EN
  assign release_s = transfer_s & req_last[grant_id_q];
`else
  logic unused_last_s;
  assign unused_last_s = ^req_last;
  assign release_s     = transfer_s;
`endif

  // On release the picker looks past the holder so another requester gets the next slot.
  always_comb begin
    pick_mask_s = '0;
    pick_ptr_s  = prio_q;
    if (release_s) begin
      pick_mask_s[grant_id_q] = 1'b1;
      pick_ptr_s              = prio_next_s;
    end else begin
      pick_ptr_s = prio_q;
    end
  end

  round_robin_picker #(
    .NUM_REQUESTERS(NUM_REQUESTERS),
    .ID_WIDTH      (ID_WIDTH)
  ) u_picker (
    .req_i  (req_valid),
    .mask_i (pick_mask_s),
    .ptr_i  (pick_ptr_s),
    .found_o(pick_found_s),
    .idx_o  (pick_idx_s)
  );

  // Write-port steering; the holder's data is driven even while full.
  always_comb begin
    req_ready  = '0;
    write_data = '0;
    if (granted_s) begin
      req_ready[grant_id_q] = ~full;
      write_data = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      req_ready  = '0;
      write_data = '0;
    end
  end

  assign increment    = transfer_s;
  assign write_enable = transfer_s;

  // Arbitration state, grant holder and round-robin pointer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      grant_id_q    <= '0;
      prio_q        <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found_s) begin
            state_q       <= ARB_GRANTED;
            grant_id_q    <= pick_idx_s;
            grant_valid_q <= 1'b1;
          end
        end
        ARB_GRANTED: begin
          if (release_s) begin
            prio_q <= prio_next_s;
            if (pick_found_s) begin
              grant_id_q <= pick_idx_s;
            end else begin
              state_q       <= ARB_IDLE;
              grant_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= ARB_IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter: per-cycle vector tables plus
// hand sequences for reset-mid-burst and word interleaving.
module tb_cdc_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          full = 1'b0;
  logic          increment;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic          grant_valid;
  logic [1:0]    grant_id;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  rl;
    logic        fl;
    logic [31:0] d;
    logic [3:0]  e_rdy;
    logic        e_inc;
    logic [7:0]  e_wd;
    logic        e_gv;
    logic [1:0]  e_gid;
  } vec_t;

  vec_t vq[$];
  logic [7:0] got_q[$];
  logic [7:0] w0[2];
  logic [7:0] w1[2];
  logic [7:0] exp6[4];
  int k0, k1, cnt;
  logic hit;

  cdc_fifo_write_arbiter #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .increment   (increment),
    .write_enable(write_enable),
    .write_data  (write_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] pk(input logic [7:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] rv, input logic [3:0] rl, input logic fl,
                     input logic [31:0] d, input logic [3:0] e_rdy, input logic e_inc,
                     input logic [7:0] e_wd, input logic e_gv, input logic [1:0] e_gid);
    vec_t v;
    v.rv = rv; v.rl = rl; v.fl = fl; v.d = d;
    v.e_rdy = e_rdy; v.e_inc = e_inc; v.e_wd = e_wd; v.e_gv = e_gv; v.e_gid = e_gid;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; full = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // Each row: inputs applied just after a rising edge, outputs sampled at the falling edge.
  task automatic run_table(input string tn);
    for (int r = 0; r < vq.size(); r++) begin
      req_valid = vq[r].rv;
      req_last  = vq[r].rl;
      full      = vq[r].fl;
      req_data  = vq[r].d;
      @(negedge clock);
      chk($sformatf("%s[%0d].req_ready", tn, r), 32'(req_ready), 32'(vq[r].e_rdy));
      chk($sformatf("%s[%0d].increment", tn, r), 32'(increment), 32'(vq[r].e_inc));
      chk($sformatf("%s[%0d].write_enable", tn, r), 32'(write_enable), 32'(vq[r].e_inc));
      chk($sformatf("%s[%0d].write_data", tn, r), 32'(write_data), 32'(vq[r].e_wd));
      chk($sformatf("%s[%0d].grant_valid", tn, r), 32'(grant_valid), 32'(vq[r].e_gv));
      if (vq[r].e_gv) begin
        chk($sformatf("%s[%0d].grant_id", tn, r), 32'(grant_id), 32'(vq[r].e_gid));
      end
      @(posedge clock);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with requests already pending.
    req_valid = 4'b1111;
    req_data  = pk(8'h13, 8'h12, 8'h11, 8'h10);
    #1 reset_n = 1'b0;
    #2;
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    chk("rst.increment", 32'(increment), 32'd0);
    chk("rst.write_enable", 32'(write_enable), 32'd0);
    chk("rst.write_data", 32'(write_data), 32'd0);
    chk("rst.grant_valid", 32'(grant_valid), 32'd0);
    chk("rst.grant_id", 32'(grant_id), 32'd0);

    // Requester 1, three words.
    do_reset();
`ifdef CDC_FIFO_ARB_BURST_LOCK_EN
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA1, 8'h0), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA1, 8'h0), 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1);
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA2, 8'h0), 4'b0010, 1'b1, 8'hA2, 1'b1, 2'd1);
    add(4'b0010, 4'b0010, 1'b0, pk(8'h0, 8'h0, 8'hA3, 8'h0), 4'b0010, 1'b1, 8'hA3, 1'b1, 2'd1);
    add(4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
`else
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA1, 8'h0), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA1, 8'h0), 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1);
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA2, 8'h0), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0010, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'hA2, 8'h0), 4'b0010, 1'b1, 8'hA2, 1'b1, 2'd1);
    add(4'b0010, 4'b0010, 1'b0, pk(8'h0, 8'h0, 8'hA3, 8'h0), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0010, 4'b0010, 1'b0, pk(8'h0, 8'h0, 8'hA3, 8'h0), 4'b0010, 1'b1, 8'hA3, 1'b1, 2'd1);
    add(4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
`endif
    run_table("single");

    // Requesters 0 and 2, two words each; then all valid proves pointer = 3.
    do_reset();
`ifdef CDC_FIFO_ARB_BURST_LOCK_EN
    add(4'b0101, 4'b0000, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h01), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0101, 4'b0000, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h01), 4'b0001, 1'b1, 8'h01, 1'b1, 2'd0);
    add(4'b0101, 4'b0001, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h02), 4'b0001, 1'b1, 8'h02, 1'b1, 2'd0);
    add(4'b0100, 4'b0000, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h00), 4'b0100, 1'b1, 8'h21, 1'b1, 2'd2);
    add(4'b0100, 4'b0100, 1'b0, pk(8'h0, 8'h22, 8'h0, 8'h00), 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2);
`else
    add(4'b0101, 4'b0000, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h01), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0101, 4'b0000, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h01), 4'b0001, 1'b1, 8'h01, 1'b1, 2'd0);
    add(4'b0101, 4'b0001, 1'b0, pk(8'h0, 8'h21, 8'h0, 8'h02), 4'b0100, 1'b1, 8'h21, 1'b1, 2'd2);
    add(4'b0101, 4'b0101, 1'b0, pk(8'h0, 8'h22, 8'h0, 8'h02), 4'b0001, 1'b1, 8'h02, 1'b1, 2'd0);
    add(4'b0100, 4'b0100, 1'b0, pk(8'h0, 8'h22, 8'h0, 8'h00), 4'b0100, 1'b1, 8'h22, 1'b1, 2'd2);
`endif
    add(4'b1111, 4'b1111, 1'b0, pk(8'h33, 8'h32, 8'h31, 8'h30), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b1000, 4'b1000, 1'b0, pk(8'h33, 8'h0, 8'h0, 8'h0), 4'b1000, 1'b1, 8'h33, 1'b1, 2'd3);
    add(4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    run_table("two_bursts");

    // Full for four cycles in the middle of requester 0's burst.
    do_reset();
`ifdef CDC_FIFO_ARB_BURST_LOCK_EN
    add(4'b0001, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h31), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0001, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h31), 4'b0001, 1'b1, 8'h31, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++)
      add(4'b0001, 4'b0000, 1'b1, pk(8'h0, 8'h0, 8'h0, 8'h32), 4'b0000, 1'b0, 8'h32, 1'b1, 2'd0);
    add(4'b0001, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h32), 4'b0001, 1'b1, 8'h32, 1'b1, 2'd0);
    add(4'b0001, 4'b0001, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h33), 4'b0001, 1'b1, 8'h33, 1'b1, 2'd0);
`else
    add(4'b0001, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h31), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0001, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h31), 4'b0001, 1'b1, 8'h31, 1'b1, 2'd0);
    add(4'b0001, 4'b0000, 1'b1, pk(8'h0, 8'h0, 8'h0, 8'h32), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    for (int i = 0; i < 3; i++)
      add(4'b0001, 4'b0000, 1'b1, pk(8'h0, 8'h0, 8'h0, 8'h32), 4'b0000, 1'b0, 8'h32, 1'b1, 2'd0);
    add(4'b0001, 4'b0000, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h32), 4'b0001, 1'b1, 8'h32, 1'b1, 2'd0);
    add(4'b0001, 4'b0001, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h33), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b0001, 4'b0001, 1'b0, pk(8'h0, 8'h0, 8'h0, 8'h33), 4'b0001, 1'b1, 8'h33, 1'b1, 2'd0);
`endif
    add(4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    run_table("full_stall");

    // All four continuously valid with single-word bursts: 0,1,2,3 then wrap to 0.
    do_reset();
    add(4'b1111, 4'b1111, 1'b0, pk(8'h43, 8'h42, 8'h41, 8'h40), 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    add(4'b1111, 4'b1111, 1'b0, pk(8'h43, 8'h42, 8'h41, 8'h40), 4'b0001, 1'b1, 8'h40, 1'b1, 2'd0);
    add(4'b1111, 4'b1111, 1'b0, pk(8'h43, 8'h42, 8'h41, 8'h40), 4'b0010, 1'b1, 8'h41, 1'b1, 2'd1);
    add(4'b1111, 4'b1111, 1'b0, pk(8'h43, 8'h42, 8'h41, 8'h40), 4'b0100, 1'b1, 8'h42, 1'b1, 2'd2);
    add(4'b1111, 4'b1111, 1'b0, pk(8'h43, 8'h42, 8'h41, 8'h40), 4'b1000, 1'b1, 8'h43, 1'b1, 2'd3);
    add(4'b0001, 4'b0001, 1'b0, pk(8'h43, 8'h42, 8'h41, 8'h40), 4'b0001, 1'b1, 8'h40, 1'b1, 2'd0);
    add(4'b0000, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
    run_table("round_robin");

    // Reset asserted while requester 2's second word is on the port.
    do_reset();
    cnt = 0;
    hit = 1'b0;
    for (int c = 0; c < 8 && !hit; c++) begin
      req_valid = 4'b0100;
      req_last  = (cnt == 1) ? 4'b0100 : 4'b0000;
      req_data  = pk(8'h0, (cnt == 0) ? 8'h51 : 8'h52, 8'h0, 8'h0);
      @(negedge clock);
      if (grant_valid && grant_id == 2'd2 && cnt == 1) begin
        hit = 1'b1;
        chk("rst_mid.pre_increment", 32'(increment), 32'd1);
        chk("rst_mid.pre_write_data", 32'(write_data), 32'h52);
        reset_n = 1'b0;
        #1;
        chk("rst_mid.req_ready", 32'(req_ready), 32'd0);
        chk("rst_mid.increment", 32'(increment), 32'd0);
        chk("rst_mid.write_enable", 32'(write_enable), 32'd0);
        chk("rst_mid.write_data", 32'(write_data), 32'd0);
        chk("rst_mid.grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_mid.grant_id", 32'(grant_id), 32'd0);
      end else begin
        if (increment) cnt++;
        @(posedge clock);
        #1;
      end
    end
    if (!hit) chk("rst_mid.second_word_reached", 32'd0, 32'd1);
    req_valid = 4'b1010;
    req_last  = 4'b1010;
    req_data  = pk(8'h63, 8'h0, 8'h61, 8'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_mid.after.grant_valid", 32'(grant_valid), 32'd1);
    chk("rst_mid.after.grant_id", 32'(grant_id), 32'd1);
    chk("rst_mid.after.req_ready", 32'(req_ready), 32'b0010);
    chk("rst_mid.after.increment", 32'(increment), 32'd1);
    chk("rst_mid.after.write_data", 32'(write_data), 32'h61);
    @(posedge clock);
    #1;

    // Requesters 0 and 1, two words each, handshake-driven.
    do_reset();
    w0[0] = 8'h61; w0[1] = 8'h62;
    w1[0] = 8'h71; w1[1] = 8'h72;
`ifdef CDC_FIFO_ARB_BURST_LOCK_EN
    exp6[0] = 8'h61; exp6[1] = 8'h62; exp6[2] = 8'h71; exp6[3] = 8'h72;
`else
    exp6[0] = 8'h61; exp6[1] = 8'h71; exp6[2] = 8'h62; exp6[3] = 8'h72;
`endif
    k0 = 0;
    k1 = 0;
    got_q.delete();
    for (int c = 0; c < 20 && (k0 < 2 || k1 < 2); c++) begin
      req_valid = {2'b00, (k1 < 2), (k0 < 2)};
      req_last  = {2'b00, (k1 == 1), (k0 == 1)};
      req_data  = pk(8'h0, 8'h0, w1[k1 & 1], w0[k0 & 1]);
      @(negedge clock);
      if (increment) got_q.push_back(write_data);
      if (req_ready[0] && req_valid[0]) k0++;
      if (req_ready[1] && req_valid[1]) k1++;
      @(posedge clock);
      #1;
    end
    req_valid = '0;
    req_last  = '0;
    chk("interleave.count", 32'(got_q.size()), 32'd4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("interleave.word%0d", j),
          32'((j < got_q.size()) ? got_q[j] : 8'h00), 32'(exp6[j]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
